// File: rtl/uart_tx_fifo_ctrl_if.sv
// Signal bundle between the UART transmit FIFO and its users: the Wishbone THR
// write path and LSR logic (master side) and the FIFO itself (slave side).
// Strobes are single-cycle qualifiers sampled on the rising clock edge. There is
// no back-pressure. A push into a full FIFO with no pop is dropped and flagged
// on overrun, and a pop from an empty FIFO is ignored.
interface uart_tx_fifo_ctrl_if #(
    parameter int FIFO_WIDTH = 8,
    parameter int COUNTER_W  = 5
) ();
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  push;
    logic                  pop;
    logic                  fifo_reset;
    logic                  reset_status;
    logic [FIFO_WIDTH-1:0] data_out;
    logic [COUNTER_W-1:0]  count;
    logic                  full;
    logic                  empty;
    logic                  overrun;

    modport master (
        output data_in, push, pop, fifo_reset, reset_status,
        input  data_out, count, full, empty, overrun
    );

    modport slave (
        input  data_in, push, pop, fifo_reset, reset_status,
        output data_out, count, full, empty, overrun
    );
endinterface

// File: rtl/uart_tx_fifo_ctrl.sv
// Transmit-side byte FIFO for the UART. THR writes push bytes in, and the
// transmitter pops one byte per frame. The head entry is always visible on
// data_out (first-word fall-through). Occupancy is tracked by a counter, and
// full/empty are derived from it, so the pointers never need comparing.
module uart_tx_fifo_ctrl #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int POINTER_W  = 4,
    parameter int COUNTER_W  = 5
) (
    input  logic                    clk,
    input  logic                    wb_rst_ni,
    uart_tx_fifo_ctrl_if.slave      bus
);

    localparam logic [COUNTER_W-1:0] DEPTH_C = COUNTER_W'(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [POINTER_W-1:0]  rd_ptr;
    logic [POINTER_W-1:0]  wr_ptr;
    logic [COUNTER_W-1:0]  count_q;
    logic                  overrun_q;

    logic                  is_full;
    logic                  is_empty;
    logic                  do_push;
    logic                  do_pop;
    logic                  overrun_evt;

    // Accept decisions. A pop frees a slot in the same cycle, so a push into a
    // full FIFO is accepted when a pop accompanies it. In an empty FIFO the
    // push wins and the pop is ignored.
    always_comb begin
        is_full     = (count_q == DEPTH_C);
        is_empty    = (count_q == '0);
        do_pop      = bus.pop && !is_empty;
        do_push     = bus.push && (!is_full || do_pop);
        overrun_evt = bus.push && is_full && !bus.pop;
    end

    // Storage write. Contents survive fifo_reset; only the hard reset clears them.
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !bus.fifo_reset) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Pointers and occupancy. fifo_reset overrides any push or pop in the same cycle.
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (bus.fifo_reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + POINTER_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + POINTER_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + COUNTER_W'(1);
                2'b01:   count_q <= count_q - COUNTER_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overrun. A new overrun event beats an LSR-read clear in the same cycle.
    always_ff @(posedge clk or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            overrun_q <= 1'b0;
        end else if (bus.fifo_reset) begin
            overrun_q <= 1'b0;
        end else if (overrun_evt) begin
            overrun_q <= 1'b1;
        end else if (bus.reset_status) begin
            overrun_q <= 1'b0;
        end
    end

    // Outputs are driven from registered state only.
    always_comb begin
        bus.data_out = mem[rd_ptr];
        bus.count    = count_q;
        bus.full     = is_full;
        bus.empty    = is_empty;
        bus.overrun  = overrun_q;
    end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl: reset state, FIFO order, full/overrun,
// simultaneous push+pop, status clear, flush and pointer wrap.
module tb_uart_tx_fifo_ctrl;

    logic clk;
    logic wb_rst_ni;
    int   checks;
    int   failures;

    uart_tx_fifo_ctrl_if #(.FIFO_WIDTH(8), .COUNTER_W(5)) bus ();

    uart_tx_fifo_ctrl #(
        .FIFO_WIDTH(8),
        .FIFO_DEPTH(16),
        .POINTER_W (4),
        .COUNTER_W (5)
    ) dut (
        .clk      (clk),
        .wb_rst_ni(wb_rst_ni),
        .bus      (bus)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one clock of strobes. The caller is positioned just after an edge.
    // The task returns 1 time unit after the next edge with the strobes low again.
    task automatic cyc(input logic p, input logic q, input logic [7:0] d,
                       input logic fr, input logic rs);
        bus.push         = p;
        bus.pop          = q;
        bus.data_in      = d;
        bus.fifo_reset   = fr;
        bus.reset_status = rs;
        @(posedge clk);
        #1;
        bus.push         = 1'b0;
        bus.pop          = 1'b0;
        bus.fifo_reset   = 1'b0;
        bus.reset_status = 1'b0;
        bus.data_in      = 8'h00;
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        bus.push         = 1'b0;
        bus.pop          = 1'b0;
        bus.data_in      = 8'h00;
        bus.fifo_reset   = 1'b0;
        bus.reset_status = 1'b0;
        wb_rst_ni        = 1'b0;
        #22;
        wb_rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // 1. Reset state.
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        chk("rst_data_out", 32'(bus.data_out), 32'h00);

        // A pop while empty is ignored.
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("empty_pop_count", 32'(bus.count), 32'd0);

        // 2. Two bytes in, two out.
        cyc(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        chk("t2_fwft_A5", 32'(bus.data_out), 32'hA5);
        cyc(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
        chk("t2_count2", 32'(bus.count), 32'd2);
        chk("t2_head_A5", 32'(bus.data_out), 32'hA5);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("t2_head_3C", 32'(bus.data_out), 32'h3C);
        chk("t2_count1", 32'(bus.count), 32'd1);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("t2_count0", 32'(bus.count), 32'd0);
        chk("t2_empty", 32'(bus.empty), 32'd1);

        // 3. Fill, overflow, drain.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
        chk("t3_full", 32'(bus.full), 32'd1);
        chk("t3_count16", 32'(bus.count), 32'd16);
        chk("t3_no_overrun_yet", 32'(bus.overrun), 32'd0);
        cyc(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        chk("t3_overrun", 32'(bus.overrun), 32'd1);
        chk("t3_count_held", 32'(bus.count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3_pop%0d", i), 32'(bus.data_out), 32'(i));
            cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        end
        chk("t3_drained_empty", 32'(bus.empty), 32'd1);
        chk("t3_drained_count", 32'(bus.count), 32'd0);

        // 5a. reset_status clears the sticky overrun.
        chk("t5_overrun_sticky", 32'(bus.overrun), 32'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("t5_status_clear", 32'(bus.overrun), 32'd0);

        // 4. Push+pop while full: data accepted, no overrun.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        chk("t4_full_pp_count", 32'(bus.count), 32'd16);
        chk("t4_full_pp_overrun", 32'(bus.overrun), 32'd0);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("t4_pop%0d", i), 32'(bus.data_out), 32'(8'h11 + i));
            cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        end
        chk("t4_last_77", 32'(bus.data_out), 32'h77);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("t4_drained", 32'(bus.count), 32'd0);
        // Push+pop from empty: push only.
        cyc(1'b1, 1'b1, 8'h42, 1'b0, 1'b0);
        chk("t4_empty_pp_count", 32'(bus.count), 32'd1);
        chk("t4_empty_pp_head", 32'(bus.data_out), 32'h42);
        cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // 5b. Overrun event beats reset_status in the same cycle.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i), 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        chk("t5_overrun_set", 32'(bus.overrun), 32'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("t5_cleared_again", 32'(bus.overrun), 32'd0);
        cyc(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1);
        chk("t5_set_wins", 32'(bus.overrun), 32'd1);
        chk("t5_count16", 32'(bus.count), 32'd16);
        chk("t5_head_kept", 32'(bus.data_out), 32'h20);

        // 6. fifo_reset overrides push and status, and clears overrun.
        cyc(1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
        chk("t6_flush_count", 32'(bus.count), 32'd0);
        chk("t6_flush_empty", 32'(bus.empty), 32'd1);
        chk("t6_flush_overrun", 32'(bus.overrun), 32'd0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
        chk("t6_five", 32'(bus.count), 32'd5);
        cyc(1'b1, 1'b1, 8'h66, 1'b1, 1'b0);
        chk("t6_flush5_count", 32'(bus.count), 32'd0);
        chk("t6_flush5_empty", 32'(bus.empty), 32'd1);

        // 6b. One seed byte, then 20 push/pop pairs wrap both pointers.
        cyc(1'b1, 1'b0, 8'h80, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t6_wrap%0d", i), 32'(bus.data_out), 32'(8'h80 + i));
            cyc(1'b1, 1'b1, 8'(8'h81 + i), 1'b0, 1'b0);
        end
        chk("t6_wrap_count", 32'(bus.count), 32'd1);
        chk("t6_wrap_tail", 32'(bus.data_out), 32'h94);

        // Asynchronous reset mid-operation discards contents without a clock edge.
        cyc(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
        #2;
        wb_rst_ni = 1'b0;
        #1;
        chk("async_rst_count", 32'(bus.count), 32'd0);
        chk("async_rst_data", 32'(bus.data_out), 32'h00);
        chk("async_rst_empty", 32'(bus.empty), 32'd1);
        @(posedge clk);
        #1;
        wb_rst_ni = 1'b1;
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_count", 32'(bus.count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
